// File: rtl/nco_multi.sv
// Time-multiplexed multi-channel NCO: one strobe streams one sine code per channel.
// Define QUARTER_WAVE_EN to store only the first quadrant of the sine table.
module nco_multi #(
    parameter int NUM_CH  = 4,
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int CODE_W  = 10,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [PHASE_W-1:0] cfg_data,
    input  logic               next_sample,
    output logic               busy,
    output logic               sample_overrun,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH_W-1:0]    out_ch,
    output logic [CODE_W-1:0]  out_code
);

    localparam int DEPTH = 1 << LUT_AW;
    localparam real PI = 3.14159265358979323846;
    localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     idx_q;
    logic                busy_q;
    logic                ovr_q;
    logic                vld_q;
    logic [CH_W-1:0]     ch_q;
    logic [CODE_W-1:0]   code_q;

    logic [PHASE_W-1:0]  acc_q [NUM_CH];
    logic [PHASE_W-1:0]  acc_d [NUM_CH];
    logic [PHASE_W-1:0]  fcw_q [NUM_CH];
    logic [PHASE_W-1:0]  fcw_d [NUM_CH];
    logic [PHASE_W-1:0]  off_q [NUM_CH];
    logic [PHASE_W-1:0]  off_d [NUM_CH];

    logic                issue;
    logic                cfg_hit;
    logic [PHASE_W-1:0]  phase;
    logic [LUT_AW-1:0]   addr;
    logic [CODE_W-1:0]   lut_data;

    // Symmetric rounding keeps the table odd-symmetric about mid-scale.
    function automatic logic [CODE_W-1:0] sine_code(input int k);
        real amp;
        real v;
        int  r;
        amp = real'((1 << (CODE_W - 1)) - 1);
        v   = amp * $sin(2.0 * PI * real'(k) / real'(DEPTH));
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        return CODE_W'((1 << (CODE_W - 1)) + r);
    endfunction

    assign issue   = (state_q == RUN) && (!vld_q || out_ready);
    assign cfg_hit = cfg_we && (int'(cfg_ch) < NUM_CH);
    assign phase   = acc_q[idx_q] + off_q[idx_q];
    assign addr    = phase[PHASE_W-1 -: LUT_AW];

`ifdef QUARTER_WAVE_EN
    localparam int QD   = DEPTH / 4;
    localparam int QA_W = LUT_AW - 1;

    logic [CODE_W-1:0] rom [QD + 1];
    logic [1:0]        quad;
    logic [LUT_AW-3:0] lo;
    logic [QA_W-1:0]   qa;
    logic [CODE_W-1:0] qv;
    logic [CODE_W:0]   neg;
    logic              unused_bits;

    for (genvar k = 0; k <= QD; k++) begin : g_rom
        assign rom[k] = sine_code(k);
    end

    // Quadrants 1/3 mirror the address, quadrants 2/3 negate about mid-scale.
    assign quad     = addr[LUT_AW-1 -: 2];
    assign lo       = addr[LUT_AW-3:0];
    assign qa       = quad[0] ? (QA_W'(QD) - {1'b0, lo}) : {1'b0, lo};
    assign qv       = rom[qa];
    assign neg      = (CODE_W+1)'(1 << CODE_W) - {1'b0, qv};
    assign lut_data = quad[1] ? neg[CODE_W-1:0] : qv;

    assign unused_bits = ^{phase[PHASE_W-LUT_AW-1:0], neg[CODE_W]};
`else
    logic [CODE_W-1:0] rom [DEPTH];
    logic              unused_bits;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = sine_code(k);
    end

    assign lut_data    = rom[addr];
    assign unused_bits = ^phase[PHASE_W-LUT_AW-1:0];
`endif

    // Clear is applied after the issue update so it wins on a collision.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i];
            fcw_d[i] = fcw_q[i];
            off_d[i] = off_q[i];
        end
        if (issue) begin
            acc_d[idx_q] = acc_q[idx_q] + fcw_q[idx_q];
        end
        if (cfg_hit) begin
            case (cfg_sel)
                2'd0:    fcw_d[cfg_ch] = cfg_data;
                2'd1:    off_d[cfg_ch] = cfg_data;
                2'd2:    acc_d[cfg_ch] = '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                fcw_q[i] <= '0;
                off_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
            fcw_q <= fcw_d;
            off_q <= off_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            vld_q   <= 1'b0;
            ch_q    <= '0;
            code_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (next_sample) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (next_sample) ovr_q <= 1'b1;
                    if (issue) begin
                        if (idx_q == LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (issue) begin
                vld_q  <= 1'b1;
                ch_q   <= idx_q;
                code_q <= lut_data;
            end else if (out_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign busy           = busy_q;
    assign sample_overrun = ovr_q;
    assign out_valid      = vld_q;
    assign out_ch         = ch_q;
    assign out_code       = code_q;

endmodule
